// File: rtl/verdict_collector_if.sv
// Monitor-side capture inputs and serialized word output of verdict_collector.
// slave = collector side, master = monitor/consumer side.
interface verdict_collector_if #(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 64,
  parameter int TS_W   = 32
);
  logic                    en;
  logic [N_OUT-1:0]        aktv;
  logic [N_OUT*DATA_W-1:0] values;
  logic                    out_valid;
  logic                    out_ready;
  logic [4:0]              out_idx;
  logic [DATA_W-1:0]       out_value;
  logic [TS_W-1:0]         out_ts;
  logic                    out_last;
  logic                    overflow;
  logic [15:0]             drop_cnt;

  modport slave (
    input  en, aktv, values, out_ready,
    output out_valid, out_idx, out_value, out_ts, out_last, overflow, drop_cnt
  );

  modport master (
    output en, aktv, values, out_ready,
    input  out_valid, out_idx, out_value, out_ts, out_last, overflow, drop_cnt
  );
endinterface

// File: rtl/verdict_collector.sv
// Captures active monitor cycles as frames in a FIFO and serializes them as (idx, value, ts) words.
// Optional capture timestamping is enabled with `define VERDICT_COLLECTOR_TS_EN.
module verdict_collector #(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  verdict_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  state_q, state_d;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic [N_OUT-1:0]        mem_aktv [DEPTH];
  logic [N_OUT*DATA_W-1:0] mem_val  [DEPTH];
  logic [N_OUT-1:0]        mask_q;
  logic [N_OUT*DATA_W-1:0] vals_q;
  logic [15:0]             drop_cnt_q;
  logic                    overflow_q;
  logic                    empty, full, push_req, push, drop, pop, hs, last, emitting;
  logic [4:0]              sel;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign emitting = (state_q == EMIT);
  assign hs       = emitting && bus.out_ready;
  assign last     = (mask_q & (mask_q - N_OUT'(1))) == '0;
  assign push_req = bus.en && (|bus.aktv);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    sel = '0;
    for (int i = N_OUT - 1; i >= 0; i--)
      if (mask_q[i]) sel = 5'(i);
  end

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (hs && last) begin
        if (!empty) pop = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mask_q     <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop)     mask_q <= mem_aktv[rd_ptr[AW-1:0]];
      else if (hs) mask_q <= mask_q & (mask_q - N_OUT'(1));
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: storage is not reset; the pointers and mask alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_aktv[wr_ptr[AW-1:0]] <= bus.aktv;
      mem_val[wr_ptr[AW-1:0]]  <= bus.values;
    end
    if (pop) vals_q <= mem_val[rd_ptr[AW-1:0]];
  end

`ifdef VERDICT_COLLECTOR_TS_EN
  logic [TS_W-1:0] ts_q, ts_head_q;
  logic [TS_W-1:0] mem_ts [DEPTH];

  always_ff @(posedge clk) begin
    if (rst)         ts_q <= '0;
    else if (bus.en) ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_ts[wr_ptr[AW-1:0]] <= ts_q;
    if (pop)  ts_head_q <= mem_ts[rd_ptr[AW-1:0]];
  end

  assign bus.out_ts = emitting ? ts_head_q : '0;
`else
  assign bus.out_ts = '0;
`endif

  // Word fields are forced to zero outside EMIT, which also yields the reset values.
  assign bus.out_valid = emitting;
  assign bus.out_idx   = emitting ? sel : '0;
  assign bus.out_value = emitting ? vals_q[int'(sel)*DATA_W +: DATA_W] : '0;
  assign bus.out_last  = emitting && last;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule
